// File: rtl/uart_tx_if.sv
// Parallel-side handshake of the 8N1 transmitter: byte + start request in,
// serial line and frame status out.
interface uart_tx_if;
  logic [7:0] data;
  logic       start;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (output data, output start, input tx, input busy, input done);
  modport slave  (input data, input start, output tx, output busy, output done);
endinterface

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: one byte per accepted start, LSB first, all outputs
// registered so the TX pin never glitches.
module uart_tx #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       reset,
  uart_tx_if.slave   bus
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (bus.start) begin
          state_d = START;
          shift_d = bus.data;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        // shift_q[0] is the bit currently on the line; [1] is the next one.
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit: frame-level model plus
// hand-computed frame patterns, busy lengths and done positions.
module tb_uart_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  uart_tx_if bus();

  int checks = 0;
  int errors = 0;

  uart_tx #(.CLK_FREQ(1000), .BAUD(250)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Frame model: time since acceptance decides everything on the line.
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  int         m_t    = 0;
  logic [7:0] m_byte = 8'h00;

  function automatic logic frame_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_t    <= 0;
    end else if (!m_busy && bus.start) begin
      m_busy <= 1'b1;
      m_t    <= 0;
      m_byte <= bus.data;
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_done <= 1'b0;
      if (m_t == 10*CPB - 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end else begin
        m_t <= m_t + 1;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    logic exp_tx;
    exp_tx = m_busy ? frame_bit(m_byte, m_t / CPB) : 1'b1;
    checks++;
    if (bus.tx !== exp_tx || bus.busy !== m_busy || bus.done !== m_done) begin
      errors++;
      $display("FAIL model t=%0t tx/busy/done got %b%b%b want %b%b%b",
               $time, bus.tx, bus.busy, bus.done, exp_tx, m_busy, m_done);
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // Starts a frame at the current negedge and watches it for 'cycles' cycles.
  // Sample i is taken after edge N+i. At sample chg_at, data becomes d2 and
  // start is raised for one cycle if pulse is set.
  task automatic run_frame(input logic [7:0] d, input int cycles,
                           input int chg_at, input logic [7:0] d2, input logic pulse,
                           output logic [9:0] bits, output int busy_n,
                           output int done_n, output int done_at);
    bus.data  = d;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bits = '0; busy_n = 0; done_n = 0; done_at = -1;
    for (int i = 0; i < cycles; i++) begin
      if (i == chg_at) begin
        bus.data  = d2;
        bus.start = pulse;
      end else if (i == chg_at + 1) begin
        bus.start = 1'b0;
      end
      if (i % CPB == 1 && i < 10*CPB) bits[i/CPB] = bus.tx;
      if (bus.busy) busy_n++;
      if (bus.done) begin done_n++; done_at = i; end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [9:0] bits;
    int busy_n, done_n, done_at, bad;
    bus.data  = 8'h00;
    bus.start = 1'b0;

    // Reset and idle hold
    repeat (3) @(negedge clk);
    checks++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got %b%b%b want 100", bus.tx, bus.busy, bus.done);
    end
    reset = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    check("idle_hold_bad_cycles", bad, 0);

    // Single byte A5
    run_frame(8'hA5, 45, -10, 8'h00, 1'b0, bits, busy_n, done_n, done_at);
    check("a5_bits", int'(bits), 10'h34A);
    check("a5_busy_cycles", busy_n, 40);
    check("a5_done_count", done_n, 1);
    check("a5_done_at", done_at, 40);

    // Data changes after acceptance must not leak into the frame
    run_frame(8'h00, 45, 0, 8'hFF, 1'b0, bits, busy_n, done_n, done_at);
    check("stable_bits", int'(bits), 10'h200);
    check("stable_busy_cycles", busy_n, 40);

    // Start while busy is ignored, not queued
    run_frame(8'h3C, 70, 10, 8'hFF, 1'b1, bits, busy_n, done_n, done_at);
    check("ignore_bits", int'(bits), 10'h278);
    check("ignore_busy_cycles", busy_n, 40);
    check("ignore_done_count", done_n, 1);

    // Back-to-back: second start raised during the done cycle
    run_frame(8'h55, 82, 40, 8'h0F, 1'b1, bits, busy_n, done_n, done_at);
    check("b2b_first_bits", int'(bits), 10'h2AA);
    check("b2b_busy_cycles", busy_n, 80);
    check("b2b_done_count", done_n, 2);
    check("b2b_second_done_at", done_at, 81);
    repeat (5) @(negedge clk);

    // Async reset mid data bit 3 (slot 4, samples 16..19)
    bus.data  = 8'hA5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (17) @(negedge clk);
    check("pre_reset_busy", int'(bus.busy), 1);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got %b%b%b want 100", bus.tx, bus.busy, bus.done);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_frame(8'hC3, 45, -10, 8'h00, 1'b0, bits, busy_n, done_n, done_at);
    check("c3_bits", int'(bits), 10'h386);
    check("c3_busy_cycles", busy_n, 40);
    check("c3_done_at", done_at, 40);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
